// File: rtl/reuleaux_triangle.sv
`timescale 1ns/1ps
// rtl/reuleaux_triangle.sv - outlined Reuleaux triangle rasteriser for a 160x120 frame buffer
//
// Draws three clipped Bresenham arcs of radius d. Each arc is centred on one
// corner of the equilateral triangle around (centre_x, centre_y). One
// candidate pixel is emitted per clock, and vga_plot qualifies it.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   colour       pixel colour, passed straight through to vga_colour
//   centre_x/y   shape centre (0..159 / 0..119)
//   diameter     triangle diameter d, also the arc radius
//   start        level request, held high until done is seen
//   done         drawing complete (held while start stays high)
//   vga_x/y      registered candidate pixel, truncated to port width
//   vga_colour   combinational copy of colour
//   vga_plot     registered write strobe for vga_x/vga_y
//
// Optional build macro: REULEAUX_SCREEN_CLIP_EN also suppresses plots whose
// untruncated coordinate falls outside the 160x120 screen.
module reuleaux_triangle (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] colour,
  input  logic [7:0] centre_x,
  input  logic [6:0] centre_y,
  input  logic [7:0] diameter,
  input  logic       start,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  typedef enum logic [2:0] {
    ARC1 = 3'b000,
    ARC2 = 3'b001,
    ARC3 = 3'b010,
    DONE = 3'b100,
    IDLE = 3'b101
  } state_t;

  state_t state, nxt_state;

  // Arc engine registers describe the candidate currently on the outputs.
  logic signed [10:0] ox, oy, crit;
  logic               phase;
  logic signed [10:0] nxt_ox, nxt_oy, nxt_crit;
  logic               nxt_phase;

  logic signed [10:0] step_ox, step_oy, step_crit;
  logic               arc_end;

  logic signed [10:0] cx, cy, r, h, b, t;
  logic signed [10:0] c1x, c1y, c2x, c2y, c3x, c3y;
  logic [7:0]         b_u, t_u;

  logic signed [10:0] cand_x, cand_y;
  logic               cand_valid, on_arc;

  assign vga_colour = colour;

  // b ~ d*sqrt(3)/6 and t ~ d*sqrt(3)/3 in 10-bit fixed point.
  assign b_u = 8'(({10'd0, diameter} * 18'd296) >> 10);
  assign t_u = 8'(({10'd0, diameter} * 18'd591) >> 10);

  assign cx = $signed({3'b000, centre_x});
  assign cy = $signed({4'b0000, centre_y});
  assign r  = $signed({3'b000, diameter});
  assign h  = $signed({4'b0000, diameter[7:1]});
  assign b  = $signed({3'b000, b_u});
  assign t  = $signed({3'b000, t_u});

  assign c1x = cx;
  assign c1y = cy - t;
  assign c2x = cx + h;
  assign c2y = cy + b;
  assign c3x = cx - h;
  assign c3y = cy + b;

  // One Bresenham step, taken after both octant pixels of the current oy.
  always_comb begin
    step_oy = oy + 11'sd1;
    if (crit <= 11'sd0) begin
      step_ox   = ox;
      step_crit = crit + (step_oy <<< 1) + 11'sd1;
    end else begin
      step_ox   = ox - 11'sd1;
      step_crit = crit + ((step_oy - step_ox) <<< 1) + 11'sd1;
    end
    arc_end = (step_oy > step_ox);
  end

  // Next state and next engine values. The engine reloads whenever an arc
  // starts, so consecutive arcs run back to back.
  always_comb begin
    nxt_state = state;
    nxt_ox    = ox;
    nxt_oy    = oy;
    nxt_crit  = crit;
    nxt_phase = phase;
    case (state)
      IDLE: begin
        if (start) begin
          nxt_state = ARC2;
          nxt_ox    = r;
          nxt_oy    = 11'sd0;
          nxt_crit  = 11'sd1 - r;
          nxt_phase = 1'b0;
        end
      end
      ARC1, ARC2, ARC3: begin
        if (!phase) begin
          nxt_phase = 1'b1;
        end else if (!arc_end) begin
          nxt_ox    = step_ox;
          nxt_oy    = step_oy;
          nxt_crit  = step_crit;
          nxt_phase = 1'b0;
        end else begin
          case (state)
            ARC2:    nxt_state = ARC3;
            ARC3:    nxt_state = ARC1;
            default: nxt_state = DONE;
          endcase
          nxt_ox    = r;
          nxt_oy    = 11'sd0;
          nxt_crit  = 11'sd1 - r;
          nxt_phase = 1'b0;
        end
      end
      DONE: begin
        if (!start) nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Candidate pixel for the next cycle, derived from the next engine values
  // so that the state and the pixel on the outputs always agree.
  always_comb begin
    cand_x     = 11'sd0;
    cand_y     = 11'sd0;
    cand_valid = 1'b1;
    on_arc     = 1'b0;
    case (nxt_state)
      ARC2: begin
        cand_x = nxt_phase ? (c2x - nxt_oy) : (c2x - nxt_ox);
        cand_y = nxt_phase ? (c2y - nxt_ox) : (c2y - nxt_oy);
        on_arc = (cand_y >= c1y) && (cand_y <= c2y) && (cand_x <= cx);
      end
      ARC3: begin
        cand_x = nxt_phase ? (c3x + nxt_oy) : (c3x + nxt_ox);
        cand_y = nxt_phase ? (c3y - nxt_ox) : (c3y - nxt_oy);
        on_arc = (cand_y >= c1y) && (cand_y <= c2y) && (cand_x >= cx);
      end
      ARC1: begin
        cand_x = nxt_phase ? (c1x - nxt_oy) : (c1x + nxt_oy);
        cand_y = c1y + nxt_ox;
        on_arc = (cand_y >= c2y) && (cand_x >= c3x) && (cand_x <= c2x);
      end
      default: cand_valid = 1'b0;
    endcase
`ifdef REULEAUX_SCREEN_CLIP_EN
    if ((cand_x < 11'sd0) || (cand_x > 11'sd159) ||
        (cand_y < 11'sd0) || (cand_y > 11'sd119)) begin
      on_arc = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ox       <= 11'sd0;
      oy       <= 11'sd0;
      crit     <= 11'sd0;
      phase    <= 1'b0;
      done     <= 1'b0;
      vga_x    <= 8'd0;
      vga_y    <= 7'd0;
      vga_plot <= 1'b0;
    end else begin
      state    <= nxt_state;
      ox       <= nxt_ox;
      oy       <= nxt_oy;
      crit     <= nxt_crit;
      phase    <= nxt_phase;
      done     <= (nxt_state == DONE);
      vga_plot <= cand_valid && on_arc;
      // Outside the arcs the last pixel coordinates are simply held.
      if (cand_valid) begin
        vga_x <= cand_x[7:0];
        vga_y <= cand_y[6:0];
      end
    end
  end

endmodule

// File: tb/tb_reuleaux_triangle.sv
`timescale 1ns/1ps
// tb/tb_reuleaux_triangle.sv - scoreboard bench for reuleaux_triangle
module tb_reuleaux_triangle;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] colour;
  logic [7:0] centre_x;
  logic [6:0] centre_y;
  logic [7:0] diameter;
  logic       start;
  logic       done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  reuleaux_triangle dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .colour     (colour),
    .centre_x   (centre_x),
    .centre_y   (centre_y),
    .diameter   (diameter),
    .start      (start),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] x;
    logic [6:0] y;
    logic       plot;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   armed  = 1'b0;

  // d=3 at (40,80): corners C1(40,79) C2(41,80) C3(39,80); pairs (ox,oy) = (3,0),(3,1),(2,2)
  exp_t d3_tab[18] = '{
    '{3'b001, 8'd38, 7'd80, 1'b1}, '{3'b001, 8'd41, 7'd77, 1'b0},
    '{3'b001, 8'd38, 7'd79, 1'b1}, '{3'b001, 8'd40, 7'd77, 1'b0},
    '{3'b001, 8'd39, 7'd78, 1'b0}, '{3'b001, 8'd39, 7'd78, 1'b0},
    '{3'b010, 8'd42, 7'd80, 1'b1}, '{3'b010, 8'd39, 7'd77, 1'b0},
    '{3'b010, 8'd42, 7'd79, 1'b1}, '{3'b010, 8'd40, 7'd77, 1'b0},
    '{3'b010, 8'd41, 7'd78, 1'b0}, '{3'b010, 8'd41, 7'd78, 1'b0},
    '{3'b000, 8'd40, 7'd82, 1'b1}, '{3'b000, 8'd40, 7'd82, 1'b1},
    '{3'b000, 8'd41, 7'd82, 1'b1}, '{3'b000, 8'd39, 7'd82, 1'b1},
    '{3'b000, 8'd42, 7'd81, 1'b0}, '{3'b000, 8'd38, 7'd81, 1'b0}
  };

  exp_t d0_tab[6] = '{
    '{3'b001, 8'd80, 7'd60, 1'b1}, '{3'b001, 8'd80, 7'd60, 1'b1},
    '{3'b010, 8'd80, 7'd60, 1'b1}, '{3'b010, 8'd80, 7'd60, 1'b1},
    '{3'b000, 8'd80, 7'd60, 1'b1}, '{3'b000, 8'd80, 7'd60, 1'b1}
  };

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every cycle the DUT shows a candidate, pop and compare.
  always @(negedge clk) begin
    if (armed && rst_n && !done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_candidate: got x=%0d y=%0d, expected none", vga_x, vga_y);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("cand_state", int'(dut.state), int'(e.st));
        chk("cand_x", int'(vga_x), int'(e.x));
        chk("cand_y", int'(vga_y), int'(e.y));
        chk("cand_plot", int'(vga_plot), int'(e.plot));
      end
    end
  end

  // Issue one draw whose expectations are already queued; wait for done.
  task automatic run_draw(input string name, input logic [7:0] x, input logic [6:0] y,
                          input logic [7:0] d, input int exp_cycles);
    int n;
    @(negedge clk);
    centre_x = x;
    centre_y = y;
    diameter = d;
    start    = 1'b1;
    @(posedge clk);
    armed = 1'b1;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    armed = 1'b0;
    chk({name, "_done"}, int'(done), 1);
    chk({name, "_done_cycle"}, n, exp_cycles);
    chk({name, "_done_plot"}, int'(vga_plot), 0);
    chk({name, "_queue_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    int offscreen;
    int plotted;
    rst_n    = 1'b0;
    colour   = 3'b101;
    centre_x = 8'd0;
    centre_y = 7'd0;
    diameter = 8'd0;
    start    = 1'b0;
    #12;
    chk("reset_state", int'(dut.state), 5);
    chk("reset_done", int'(done), 0);
    chk("reset_plot", int'(vga_plot), 0);
    chk("reset_x", int'(vga_x), 0);
    chk("reset_y", int'(vga_y), 0);
    chk("colour_pass", int'(vga_colour), 5);
    @(negedge clk);
    rst_n = 1'b1;

    // d=3 draw: full candidate sequence including arc order.
    foreach (d3_tab[i]) exp_q.push_back(d3_tab[i]);
    run_draw("d3", 8'd40, 7'd80, 8'd3, 19);

    // done holds while start stays high.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_done", int'(done), 1);
      chk("hold_plot", int'(vga_plot), 0);
    end
    start = 1'b0;
    @(negedge clk);
    chk("drop_done", int'(done), 0);
    chk("drop_state", int'(dut.state), 5);

    // Redraw gives the identical sequence.
    foreach (d3_tab[i]) exp_q.push_back(d3_tab[i]);
    run_draw("d3_again", 8'd40, 7'd80, 8'd3, 19);
    start = 1'b0;
    @(negedge clk);

    // d=0: only the centre pixel pair per arc.
    foreach (d0_tab[i]) exp_q.push_back(d0_tab[i]);
    run_draw("d0", 8'd80, 7'd60, 8'd0, 7);
    start = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of ARC3.
    centre_x = 8'd40;
    centre_y = 7'd80;
    diameter = 8'd3;
    start    = 1'b1;
    repeat (9) @(posedge clk);
    #2;
    chk("mid_arc3_state", int'(dut.state), 2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", int'(dut.state), 5);
    chk("async_rst_done", int'(done), 0);
    chk("async_rst_plot", int'(vga_plot), 0);
    chk("async_rst_x", int'(vga_x), 0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_state", int'(dut.state), 5);

    // d=60 at (5,5): large parts of the shape fall off screen.
    centre_x = 8'd5;
    centre_y = 7'd5;
    diameter = 8'd60;
    start    = 1'b1;
    @(posedge clk);
    n = 0;
    offscreen = 0;
    plotted = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
      if (vga_plot) begin
        plotted++;
        if (vga_x > 8'd159 || vga_y > 7'd119) offscreen++;
      end
    end
    chk("d60_done", int'(done), 1);
    chk("d60_some_plots", int'(plotted > 0), 1);
`ifdef REULEAUX_SCREEN_CLIP_EN
    chk("d60_offscreen_plots", offscreen, 0);
`else
    chk("d60_truncated_plots_seen", int'(offscreen > 0), 1);
`endif
    start = 1'b0;
    @(negedge clk);
    chk("d60_idle", int'(dut.state), 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
